serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- Receive end of the team's serial link: samples a single-wire serial line, detects start bit, shifts in a DATA_W-bit word LSB first, checks the stop bit.
- Presents the word on a parallel output with a valid/ack handshake.
- Bit position is tracked by a loadable down-counter that flags zero.
- Sits opposite the transmit-side loadable down-counter/shifter on the same link.

Parameters:
- DATA_W, 8, payload bits per frame
- CLKS_PER_BIT, 4, clk cycles per serial bit (>=2, even)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- serial_in  in  1  serial line; idle high
- data_ack  in  1  consumer accepts data_out this cycle
- data_out  out  DATA_W  received word
- data_valid  out  1  data_out holds an unconsumed word
- parity_err  out  1  parity mismatch on the word in data_out; qualified by data_valid
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  sticky: frame completed while data_valid=1 and no ack
- busy  out  1  state != IDLE

Behaviour:
- Frame format: start(0), DATA_W data bits LSB first, [parity], stop(1).
- Reset (rst=0, async): state=IDLE, all outputs 0, shift register 0, counters 0. Reset mid-frame aborts the frame; nothing is delivered.
- tick_cnt: down-counter over CLKS_PER_BIT; a sample is taken when tick_cnt==0, then it reloads with CLKS_PER_BIT-1.
- bit_cnt: down-counter over data bits; its zero flag ends the DATA state.
- States and transitions:
  - IDLE: serial_in==0 -> START; load tick_cnt = CLKS_PER_BIT/2-1 (mid-bit alignment).
  - START: sample at tick 0. If 0 -> DATA, load bit_cnt = DATA_W-1. If 1 -> IDLE (glitch; no error).
  - DATA: at each sample, shift_reg <= {serial_in, shift_reg[DATA_W-1:1]}. If bit_cnt==0 -> PARITY (feature on) or STOP; else bit_cnt decrements.
  - PARITY: sample, store parity check, -> STOP.
  - STOP: sample. If 1: deliver, -> IDLE. If 0: frame_err=1 for one cycle, no delivery, -> BREAK.
  - BREAK: wait for serial_in==1 -> IDLE. Prevents re-triggering on a held-low line.
- Deliver, registered on the sample cycle:
  - data_valid=0 or data_ack=1 that cycle: data_out <= shift_reg, parity_err <= check result, data_valid <= 1.
  - Otherwise: data_out is not overwritten, the new word is dropped, overrun <= 1.
- data_ack with data_valid=1 and no delivery that cycle: data_valid <= 0 and overrun <= 0 next edge.
- data_ack while data_valid=0: ignored.
- Latency: data_valid rises on the clk edge at the mid-sample of the stop bit.
- busy=1 from the edge after start detect until return to IDLE.

Optional Feature:
- Macro: SERIAL_RX_PARITY_CHECK_EN.
- Defined: frame carries an even-parity bit after the data bits. parity_err = XOR(data bits, parity bit); set together with delivery.
- Undefined: no PARITY state and no parity bit in the frame; parity_err is tied 0.

Decomposition:
- Package serial_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, BREAK)
  - the IDLE_LEVEL=1, START_LEVEL=0 and STOP_LEVEL=1 constants
- One sub-module, rx_bit_counter: a parameterised-width loadable down-counter with load, enable and a zero flag.
  - Instanced twice in serial_receiver: once for tick_cnt, once for bit_cnt.

Test Plan:
- Reset: rst=0 asserted mid-frame, then released -> all outputs 0, state IDLE; next valid frame is received correctly.
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, send 0xA5 (bits 1,0,1,0,0,1,0,1), stop=1 -> data_out=0xA5, data_valid=1 until data_ack, frame_err=0.
- Glitch: serial_in low for 1 cycle then high -> no data_valid, busy returns to 0 within 2 cycles.
- Framing error: send 0x3C with stop=0, hold line low 10 cycles -> frame_err pulses once, no data_valid, busy stays 1 until line goes high.
- Overrun:
  - Send 0x11 with no ack, then send 0x22 -> data_out stays 0x11, overrun=1; data_ack clears both.
  - Repeat with data_ack on the delivery cycle -> data_out=0x22, overrun=0.
- Parity (macro defined): 0x07 with parity bit 1 -> parity_err=0; same with parity bit 0 -> parity_err=1 with data_valid.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receive path: FSM state encoding,
// line levels and a counter-width helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Loadable down-counter with enable and a zero flag; load wins over enable.
module rx_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_receiver.sv
// Serial link receiver: start detect, LSB-first shift-in, stop check and a
// valid/ack output port. Define SERIAL_RX_PARITY_CHECK_EN for even parity.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int TICK_W = cnt_w(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_w(DATA_W);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  rx_state_e         state, next_state;
  logic [DATA_W-1:0] shift_reg;
  logic              tick_load, tick_en, tick_zero;
  logic [TICK_W-1:0] tick_val;
  logic              bit_load, bit_en, bit_zero;
  logic              shift_en, deliver, stop_bad;
  logic              accept;

  rx_bit_counter #(.W(TICK_W)) u_tick_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tick_load),
    .en       (tick_en),
    .load_val (tick_val),
    .zero     (tick_zero)
  );

  rx_bit_counter #(.W(BIT_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .en       (bit_en),
    .load_val (BIT_LAST),
    .zero     (bit_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic par_en;
`endif

  // NOTE: every signal assigned here gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    next_state = state;
    tick_load  = 1'b0;
    tick_val   = TICK_FULL;
    tick_en    = 1'b0;
    bit_load   = 1'b0;
    bit_en     = 1'b0;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    par_en     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (serial_in == START_LEVEL) begin
          next_state = START;
          tick_load  = 1'b1;
          tick_val   = TICK_MID;
        end
      end
      START: begin
        if (tick_zero) begin
          tick_load = 1'b1;
          if (serial_in == START_LEVEL) begin
            next_state = DATA;
            bit_load   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          tick_en = 1'b1;
        end
      end
      DATA: begin
        if (tick_zero) begin
          tick_load = 1'b1;
          shift_en  = 1'b1;
          if (bit_zero) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end else begin
            bit_en = 1'b1;
          end
        end else begin
          tick_en = 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_CHECK_EN
      PARITY: begin
        if (tick_zero) begin
          tick_load  = 1'b1;
          par_en     = 1'b1;
          next_state = STOP;
        end else begin
          tick_en = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick_zero) begin
          tick_load = 1'b1;
          if (serial_in == STOP_LEVEL) begin
            deliver    = 1'b1;
            next_state = IDLE;
          end else begin
            stop_bad   = 1'b1;
            next_state = BREAK;
          end
        end else begin
          tick_en = 1'b1;
        end
      end
      BREAK: begin
        // Hold here until the line returns idle so a stuck-low line is not
        // mistaken for a stream of start bits.
        if (serial_in == IDLE_LEVEL) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A new word may land only if the output slot is free or being freed.
  assign accept = deliver && (!data_valid || data_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (shift_en) shift_reg <= {serial_in, shift_reg[DATA_W-1:1]};
      if (accept) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        overrun    <= 1'b0;
      end else if (deliver) begin
        overrun <= 1'b1;
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bad <= (^shift_reg) ^ serial_in;
      if (accept) parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: reset, basic frame, glitch, framing
// error, overrun and (with SERIAL_RX_PARITY_CHECK_EN) parity.
module tb_serial_receiver;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          data_ack;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int n_vec  = 0;
  int n_err  = 0;
  int fe_cnt = 0;
  int fe_base;

`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic par_flip = 1'b0;
`endif

  serial_receiver #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called on a negedge; leaves the line at the stop level. With ack_stop the
  // ack is held across exactly the stop-bit sample edge.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic ack_stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_CHECK_EN
    send_bit((^d) ^ par_flip);
`endif
    serial_in = stop_b;
    repeat (CPB / 2) @(negedge clk);
    if (ack_stop) data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk);
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    serial_in = 1'b1;
    data_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_parity", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame aborts it.
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    serial_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    check("mid_no_deliver", 32'(data_valid), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post_rst_data", 32'(data_out), 32'h5A);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    pulse_ack();
    check("post_rst_ack", 32'(data_valid), 32'h0);

    // Basic frame.
    fe_base = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_valid", 32'(data_valid), 32'h1);
    check("a5_parity", 32'(parity_err), 32'h0);
    repeat (6) @(negedge clk);
    check("a5_valid_hold", 32'(data_valid), 32'h1);
    check("a5_no_frame_err", 32'(fe_cnt - fe_base), 32'h0);
    pulse_ack();
    check("a5_ack", 32'(data_valid), 32'h0);

    // Ack with nothing pending is ignored.
    pulse_ack();
    check("idle_ack_valid", 32'(data_valid), 32'h0);
    check("idle_ack_overrun", 32'(overrun), 32'h0);

    // One-cycle glitch on the line.
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    check("glitch_busy", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    check("glitch_idle", 32'(busy), 32'h0);
    repeat (CPB * 12) @(negedge clk);
    check("glitch_no_valid", 32'(data_valid), 32'h0);

    // Framing error with the line held low afterwards.
    fe_base = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("fe_pulse_count", 32'(fe_cnt - fe_base), 32'h1);
    check("fe_no_valid", 32'(data_valid), 32'h0);
    check("fe_busy_held", 32'(busy), 32'h1);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    check("fe_busy_release", 32'(busy), 32'h0);

    // Overrun: second word dropped when the first is not consumed.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_data", 32'(data_out), 32'h11);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(data_valid), 32'h1);
    pulse_ack();
    check("ovr_ack_valid", 32'(data_valid), 32'h0);
    check("ovr_ack_flag", 32'(overrun), 32'h0);

    // Ack on the delivery edge lets the new word in.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    check("swap_data", 32'(data_out), 32'h22);
    check("swap_overrun", 32'(overrun), 32'h0);
    check("swap_valid", 32'(data_valid), 32'h1);
    pulse_ack();

`ifdef SERIAL_RX_PARITY_CHECK_EN
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_ok_valid", 32'(data_valid), 32'h1);
    check("par_ok_err", 32'(parity_err), 32'h0);
    pulse_ack();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_valid", 32'(data_valid), 32'h1);
    check("par_bad_data", 32'(data_out), 32'h07);
    check("par_bad_err", 32'(parity_err), 32'h1);
    pulse_ack();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
